// File: rtl/button_input_conditioner.sv
// rtl/button_input_conditioner.sv - per-channel sync, debounce, press/release/hold/repeat pulses
module button_input_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 100000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_LIM  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_SV = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_M1  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM_ON  = 2'd1,
        PRESSED = 2'd2,
        ARM_OFF = 2'd3
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : gen_ch
        logic [1:0]    sync_q;
        state_t        state_q, state_d;
        logic [CW-1:0] db_q, db_d, db_inc;
        logic [CW-1:0] hold_q, hold_d;
        logic [CW-1:0] rep_q, rep_d;
        logic          hold_done_q, hold_done_d;
        logic          level_q, press_q, release_q, hold_q_p, rep_q_p;
        logic          level_d, press_d, release_d, hold_p_d, rep_p_d;
        logic          s;

        assign s = sync_q[1];
        // The cycle that leaves a stable state already counts as the first stable sample.
        assign db_inc = ((state_q == IDLE || state_q == PRESSED) ? '0 : db_q) + CW'(1);

        always_comb begin
            state_d     = state_q;
            db_d        = db_q;
            hold_d      = hold_q;
            rep_d       = rep_q;
            hold_done_d = hold_done_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            hold_p_d    = 1'b0;
            rep_p_d     = 1'b0;

            case (state_q)
                IDLE, ARM_ON: begin
                    if (!s) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else if (db_inc >= DB_LIM) begin
                        state_d = PRESSED;
                        db_d    = '0;
                        press_d = 1'b1;
                    end else begin
                        state_d = ARM_ON;
                        db_d    = db_inc;
                    end
                end
                PRESSED, ARM_OFF: begin
                    if (s) begin
                        state_d = PRESSED;
                        db_d    = '0;
                    end else if (db_inc >= DB_LIM) begin
                        state_d     = IDLE;
                        db_d        = '0;
                        release_d   = 1'b1;
                        hold_d      = '0;
                        rep_d       = '0;
                        hold_done_d = 1'b0;
                    end else begin
                        state_d = ARM_OFF;
                        db_d    = db_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    db_d    = '0;
                end
            endcase

            // Hold/repeat run while the debounced level is high, glitches included.
            if ((state_q == PRESSED || state_q == ARM_OFF) && !release_d) begin
                if (!hold_done_q) begin
                    if (hold_q == HOLD_M1) begin
                        hold_d      = HOLD_SV;
                        hold_done_d = 1'b1;
                        hold_p_d    = 1'b1;
                        rep_d       = '0;
                    end else begin
                        hold_d = hold_q + CW'(1);
                    end
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_q == REP_M1) begin
                        rep_d   = '0;
                        rep_p_d = 1'b1;
                    end else begin
                        rep_d = rep_q + CW'(1);
                    end
                end
            end

            level_d = (state_d == PRESSED) || (state_d == ARM_OFF);
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sync_q      <= '0;
                state_q     <= IDLE;
                db_q        <= '0;
                hold_q      <= '0;
                rep_q       <= '0;
                hold_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                hold_q_p    <= 1'b0;
                rep_q_p     <= 1'b0;
            end else begin
                sync_q      <= {sync_q[0], btn_raw[i]};
                state_q     <= state_d;
                db_q        <= db_d;
                hold_q      <= hold_d;
                rep_q       <= rep_d;
                hold_done_q <= hold_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                hold_q_p    <= hold_p_d;
                rep_q_p     <= rep_p_d;
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_hold[i]    = hold_q_p;
        assign btn_repeat[i]  = rep_q_p;
    end

endmodule
